// File: rtl/relay_link_arbiter_if.sv
// relay_link_arbiter_if: request/frame/status bundle between the two frame
// sources and the relay link arbiter.
// master = requester side, slave = arbiter side.
interface relay_link_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        req;
  logic [DATA_W-1:0] frame0;
  logic [DATA_W-1:0] frame1;
  logic [1:0]        ack;
  logic [1:0]        done;
  logic [1:0]        gnt;
  logic              busy;
  logic              data_out;

  modport master (
    output req, frame0, frame1,
    input  ack, done, gnt, busy, data_out
  );

  modport slave (
    input  req, frame0, frame1,
    output ack, done, gnt, busy, data_out
  );
endinterface

// File: rtl/relay_link_arbiter.sv
// relay_link_arbiter: shares one serial relay link between the reader
// (requester 0) and the tag side (requester 1). Each granted frame is sent
// as a 32-bit preamble, a DATA_W-bit payload (MSB first), then GUARD_LEN
// idle zeros. The cycle after the frame has a one-cycle done pulse.
// Optional build macro RELAY_ARB_FIXED_PRIO_EN: requester 0 always wins
// contention; otherwise contention is resolved round-robin.
module relay_link_arbiter #(
  parameter int          DATA_W    = 32,
  parameter int          GUARD_LEN = 8,
  parameter logic [31:0] PREAMBLE  = 32'hFFFF0000
) (
  input  logic                clk,
  input  logic                reset,
  relay_link_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRE   = 2'd1,
    S_PAY   = 2'd2,
    S_GUARD = 2'd3
  } state_t;

  // Counter reload values: each state lasts (reload + 1) cycles.
  localparam logic [7:0] PRE_LAST = 8'd31;
  localparam logic [7:0] PAY_LAST = 8'(DATA_W - 1);
  localparam logic [7:0] GRD_LAST = (GUARD_LEN > 0) ? 8'(GUARD_LEN - 1) : 8'd0;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  state_t            r_state;
  state_t            w_state_nx;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_nx;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nx;
  logic              r_owner;
  logic              w_owner_nx;
  logic              w_win;
  logic              w_start;

  logic [1:0]        r_ack;
  logic [1:0]        r_gnt;
  logic [1:0]        r_done;
  logic              r_busy;
  logic              r_data;
  logic [1:0]        w_ack_nx;
  logic [1:0]        w_gnt_nx;
  logic [1:0]        w_done_nx;
  logic              w_busy_nx;
  logic              w_data_nx;

`ifndef RELAY_ARB_FIXED_PRIO_EN
  // Index of the most recent winner; reset to 1 so requester 0 wins first.
  logic              r_last_gnt;
`endif

  // Pick the winner among active requesters for this IDLE cycle.
  always_comb begin
    w_win = 1'b0;
`ifdef RELAY_ARB_FIXED_PRIO_EN
    w_win = ~bus.req[0];
`else
    case (bus.req)
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_last_gnt;
      default: w_win = 1'b0;
    endcase
`endif
  end

  assign w_start = (r_state == S_IDLE) && (bus.req != 2'b00);

  // State, counter and payload register updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_owner <= w_owner_nx;
    end
  end

  // Round-robin history, only moves when a frame is granted.
`ifndef RELAY_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_gnt <= 1'b1;
    end else if (w_start) begin
      r_last_gnt <= w_win;
    end
  end
`endif

  // Payload shifter is pure data and needs no reset.
  always_ff @(posedge clk) begin
    r_shift <= w_shift_nx;
  end

  // Next-state, counter, shifter and owner logic.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_shift_nx = r_shift;
    w_owner_nx = r_owner;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nx = S_PRE;
          w_cnt_nx   = PRE_LAST;
          w_shift_nx = w_win ? bus.frame1 : bus.frame0;
          w_owner_nx = w_win;
        end
      end
      S_PRE: begin
        if (r_cnt == 8'd0) begin
          w_state_nx = S_PAY;
          w_cnt_nx   = PAY_LAST;
        end else begin
          w_cnt_nx = r_cnt - 8'd1;
        end
      end
      S_PAY: begin
        if (r_cnt == 8'd0) begin
          if (GUARD_LEN == 0) begin
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_GUARD;
            w_cnt_nx   = GRD_LAST;
          end
        end else begin
          w_cnt_nx   = r_cnt - 8'd1;
          w_shift_nx = r_shift << 1;
        end
      end
      S_GUARD: begin
        if (r_cnt == 8'd0) begin
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt - 8'd1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state so
  // that every output can be registered without an extra cycle of lag.
  always_comb begin
    w_data_nx = 1'b0;
    w_ack_nx  = 2'b00;
    w_gnt_nx  = 2'b00;
    w_done_nx = 2'b00;
    w_busy_nx = 1'b0;
    case (w_state_nx)
      S_PRE:   w_data_nx = PREAMBLE[w_cnt_nx[4:0]];
      S_PAY:   w_data_nx = w_shift_nx[DATA_W-1];
      default: w_data_nx = 1'b0;
    endcase
    if (w_state_nx != S_IDLE) begin
      w_busy_nx = 1'b1;
      w_gnt_nx  = onehot(w_owner_nx);
    end
    if (w_start) begin
      w_ack_nx = onehot(w_win);
    end
    if ((r_state != S_IDLE) && (w_state_nx == S_IDLE)) begin
      w_done_nx = onehot(r_owner);
    end
  end

  // Registered outputs; reset drops everything to zero with no done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack  <= 2'b00;
      r_gnt  <= 2'b00;
      r_done <= 2'b00;
      r_busy <= 1'b0;
      r_data <= 1'b0;
    end else begin
      r_ack  <= w_ack_nx;
      r_gnt  <= w_gnt_nx;
      r_done <= w_done_nx;
      r_busy <= w_busy_nx;
      r_data <= w_data_nx;
    end
  end

  assign bus.ack      = r_ack;
  assign bus.gnt      = r_gnt;
  assign bus.done     = r_done;
  assign bus.busy     = r_busy;
  assign bus.data_out = r_data;

endmodule

// File: tb/tb_relay_link_arbiter.sv
// tb_relay_link_arbiter: drives two arbiter instances (default config and
// DATA_W=8 / GUARD_LEN=0) from shared randomized stimulus. A frame-level
// reference model queues the expected per-cycle outputs; a monitor on the
// falling edge pops and compares them.
module tb_relay_link_arbiter;

  typedef struct packed {
    logic       d;
    logic [1:0] ack;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
  } rec_t;

  localparam logic [31:0] PRE_WORD = 32'hFFFF0000;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [63:0] f0;
  logic [63:0] f1;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int DW = (g == 0) ? 32 : 8;
    localparam int GL = (g == 0) ? 8 : 0;

    relay_link_arbiter_if #(.DATA_W(DW)) bus ();

    assign bus.req    = req;
    assign bus.frame0 = f0[DW-1:0];
    assign bus.frame1 = f1[DW-1:0];

    relay_link_arbiter #(.DATA_W(DW), .GUARD_LEN(GL)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
    );

    rec_t sb[$];
    rec_t pend[$];
    int   last_w = 1;

    // Reference model: on a grant the whole frame's per-cycle outputs are
    // laid out at once; every edge moves one expected cycle to the scoreboard.
    always @(posedge clk) begin
      rec_t        r;
      logic [63:0] fr;
      logic [1:0]  oh;
      int          w;
      if (rst) begin
        pend.delete();
        last_w = 1;
        sb.push_back('0);
      end else begin
        if (pend.size() == 0 && req != 2'b00) begin
`ifdef RELAY_ARB_FIXED_PRIO_EN
          w = req[0] ? 0 : 1;
`else
          if (req == 2'b11) w = (last_w == 1) ? 0 : 1;
          else              w = req[0] ? 0 : 1;
`endif
          last_w = w;
          fr = (w == 1) ? f1 : f0;
          oh = (w == 1) ? 2'b10 : 2'b01;
          for (int k = 0; k < 32; k++) begin
            r = '0; r.d = PRE_WORD[31-k]; r.gnt = oh; r.busy = 1'b1;
            if (k == 0) r.ack = oh;
            pend.push_back(r);
          end
          for (int k = 0; k < DW; k++) begin
            r = '0; r.d = fr[DW-1-k]; r.gnt = oh; r.busy = 1'b1;
            pend.push_back(r);
          end
          for (int k = 0; k < GL; k++) begin
            r = '0; r.gnt = oh; r.busy = 1'b1;
            pend.push_back(r);
          end
          r = '0; r.done = oh;
          pend.push_back(r);
        end
        if (pend.size() != 0) sb.push_back(pend.pop_front());
        else                  sb.push_back('0);
      end
    end

    // Monitor: compare every cycle's outputs away from the active edge.
    always @(negedge clk) begin
      rec_t a;
      rec_t e;
      a.d = bus.data_out; a.ack = bus.ack; a.gnt = bus.gnt;
      a.done = bus.done;  a.busy = bus.busy;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL cfg%0d scoreboard_empty t=%0t got d=%b ack=%b gnt=%b done=%b busy=%b, no expectation queued",
                 g, $time, a.d, a.ack, a.gnt, a.done, a.busy);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL cfg%0d cycle_outputs t=%0t got d=%b ack=%b gnt=%b done=%b busy=%b, expected d=%b ack=%b gnt=%b done=%b busy=%b",
                   g, $time, a.d, a.ack, a.gnt, a.done, a.busy,
                   e.d, e.ack, e.gnt, e.done, e.busy);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    rst = 1'b1;
    req = 2'b00;
    f0  = '0;
    f1  = '0;
    step(3);
    rst = 1'b0;
    step(2);

    // Single one-cycle request from requester 0 with the reference payload.
    f0  = 64'h0000_0000_A5A5_0F0F;
    req = 2'b01;
    step(1);
    req = 2'b00;
    f0  = rnd64();
    step(80);

    // Both requesting continuously: grants should alternate.
    f0  = rnd64();
    f1  = rnd64();
    req = 2'b11;
    repeat (8) begin
      step(37);
      f0 = rnd64();
      f1 = rnd64();
    end
    req = 2'b00;
    step(80);

    // Requester 1 joins while requester 0 owns the link.
    req = 2'b01;
    step(10);
    req = 2'b11;
    step(150);
    req = 2'b00;
    step(80);

    // Reset during the payload of a default-config frame, then a fresh frame.
    f0  = rnd64();
    req = 2'b01;
    step(1);
    req = 2'b00;
    step(42);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
    f1  = rnd64();
    req = 2'b10;
    step(1);
    req = 2'b00;
    step(80);

    // Randomized traffic with occasional resets.
    repeat (4000) begin
      req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) req = 2'b00;
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) f0 = rnd64();
      if ($urandom_range(0, 7) == 0) f1 = rnd64();
      step(1);
    end
    rst = 1'b0;
    req = 2'b00;
    step(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
